// File: rtl/armcore_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : armcore_pkg                                                |
// | Purpose : Shared widths and the fetch buffer entry type for the      |
// |           ArmCore front end.                                         |
// | Contents: INSTR_W, ADDR_W, INSTR_BYTES, fetch_entry_t {instr, pc}    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package armcore_pkg;

  localparam int INSTR_W     = 32;
  localparam int ADDR_W      = 64;
  localparam int INSTR_BYTES = 4;

  // One buffered fetch: the instruction word and the address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fetch_fifo                                                 |
// | Purpose : DEPTH-entry synchronous FIFO with flush, used for both the |
// |           instruction buffer and the request-address tag queue.      |
// | Ports   : clk, rst_n        clock / async active-low reset           |
// |           flush             empty the FIFO (wins over push)          |
// |           push, push_data   write side                               |
// |           pop,  pop_data    read side (pop_data = head entry)        |
// |           count             current occupancy, 0..DEPTH              |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fetch_unit                                                 |
// | Purpose : ArmCore instruction fetch stage. Owns the PC, issues word  |
// |           requests, buffers returned words with their PC and hands   |
// |           them in order to decode. A redirect flushes everything in  |
// |           flight; late words of the old stream are counted and       |
// |           dropped.                                                   |
// | Ports   : clk, rst_n                      clock / async reset (low)  |
// |           imem_req_valid/ready/addr       request channel            |
// |           imem_rsp_valid/data             in-order response channel  |
// |           redirect_valid/pc               taken branch / flush       |
// |           dec_valid/ready/instr/pc        decode handshake           |
// |           fetch_fault                     misaligned redirect seen   |
// | Config  : FETCH_ALIGN_CHECK_EN - misaligned redirect raises a sticky |
// |           fetch_fault and halts requests until reset. Undefined:     |
// |           redirect_pc[1:0] is forced to zero, fetch_fault tied low.  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fetch_unit
  import armcore_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic               fetch_fault
);

  localparam int CNT_W   = $clog2(DEPTH+1);
  // Repeated redirects can stack an old epoch's leftovers on top of the
  // current one, so the drop counter is sized for twice the credit window.
  localparam int STALE_W = $clog2(2*DEPTH+1);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [STALE_W-1:0] stale_q, stale_d;

  logic [CNT_W-1:0]   buf_count;
  logic [CNT_W-1:0]   unused_tag_count;
  logic [ADDR_W-1:0]  tag_head;
  fetch_entry_t       buf_push_entry;
  fetch_entry_t       buf_head;

  logic               req_fire;
  logic               rsp_live;
  logic               rsp_stale;
  logic               dec_fire;
  logic               credit_ok;
  logic               halt;
  logic [ADDR_W-1:0]  target_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign target_pc = redirect_pc;

  always_comb begin
    fault_d = fault_q;
    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign halt        = fault_q;
  assign fetch_fault = fault_q;
`else
  logic [1:0] unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];
  assign target_pc            = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign halt                 = 1'b0;
  assign fetch_fault          = 1'b0;
`endif

  // Credit: words already buffered plus words still owed by memory must
  // leave room, so every live response is guaranteed a buffer slot.
  assign credit_ok = ({1'b0, buf_count} + {1'b0, outstanding_q}) < (CNT_W+1)'(DEPTH);

  // rst_n gates the request so nothing is offered while reset is held.
  assign imem_req_valid = rst_n && !redirect_valid && !halt && credit_ok;
  assign imem_req_addr  = pc_q;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign rsp_stale = imem_rsp_valid && (stale_q != '0);
  assign rsp_live  = imem_rsp_valid && (stale_q == '0);
  assign dec_fire  = dec_valid && dec_ready;

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    stale_d       = stale_q;
    if (redirect_valid) begin
      // Everything still owed from the old stream becomes stale; a live
      // word arriving now is already paid for and is discarded by the flush.
      pc_d          = target_pc;
      outstanding_d = '0;
      stale_d       = stale_q + STALE_W'(outstanding_q)
                    - STALE_W'(rsp_stale) - STALE_W'(rsp_live);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + ADDR_W'(INSTR_BYTES);
      end
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
      stale_d       = stale_q - STALE_W'(rsp_stale);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

  // Tag queue: request addresses in issue order, matched to live responses.
  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_live),
    .pop_data  (tag_head),
    .count     (unused_tag_count)
  );

  assign buf_push_entry = '{instr: imem_rsp_data, pc: tag_head};

  // Instruction buffer presented to decode.
  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_live),
    .push_data (buf_push_entry),
    .pop       (dec_fire),
    .pop_data  (buf_head),
    .count     (buf_count)
  );

  assign dec_valid = (buf_count != '0);
  assign dec_instr = buf_head.instr;
  assign dec_pc    = buf_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fetch_unit                                              |
// | Purpose : Directed self-checking bench for fetch_unit with a         |
// |           one-cycle in-order memory and an in-order PC model.        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .fetch_fault    (fetch_fault)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] mq[$];      // addresses accepted by memory, awaiting response
  bit          mem_en;     // memory returns a word each cycle when set
  logic [63:0] exp_pc;     // next PC decode should see
  logic [63:0] exp_req;    // next address the fetch unit should request
  int          n_reqs = 0;
  int          n_pops = 0;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return 32'hD2800020 + a[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: sample handshakes, advance the models, then drive memory.
  task automatic tick();
    logic        s_req;
    logic        s_dec;
    logic [63:0] s_addr;
    logic [63:0] s_dpc;
    logic [31:0] s_din;
    #1;
    s_req  = imem_req_valid && imem_req_ready;
    s_addr = imem_req_addr;
    s_dec  = dec_valid && dec_ready;
    s_dpc  = dec_pc;
    s_din  = dec_instr;
    if (s_dec) begin
      chk("dec_pc_order", s_dpc, exp_pc);
      chk("dec_instr", {32'h0, s_din}, {32'h0, instr_of(exp_pc)});
      exp_pc = exp_pc + 64'd4;
      n_pops++;
    end
    if (s_req) begin
      chk("req_addr_seq", s_addr, exp_req);
      exp_req = exp_req + 64'd4;
      n_reqs++;
    end
    @(posedge clk);
    if (s_req) mq.push_back(s_addr);
    if (redirect_valid) begin
      exp_pc  = {redirect_pc[63:2], 2'b00};
      exp_req = {redirect_pc[63:2], 2'b00};
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    if (mem_en && mq.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
  endtask

  task automatic wait_dec(input string tag, input logic [63:0] exp_v);
    int k = 0;
    while (!dec_valid && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, 64'(dec_valid), 64'd1);
    chk(tag, dec_pc, exp_v);
  endtask

  initial begin
    int saved;
    int k;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    dec_ready      = 1'b0;
    mem_en         = 1'b0;
    exp_pc         = 64'h0;
    exp_req        = 64'h0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", imem_req_addr, 64'h0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_dec_instr", {32'h0, dec_instr}, 64'h0);
    chk("rst_dec_pc", dec_pc, 64'h0);
    chk("rst_fault", 64'(fetch_fault), 64'd0);

    // Release: first request immediately, response next cycle, decode after.
    @(negedge clk);
    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    mem_en         = 1'b1;
    #1;
    chk("c0_req_valid", 64'(imem_req_valid), 64'd1);
    chk("c0_req_addr", imem_req_addr, 64'h0);
    chk("c0_dec_valid", 64'(dec_valid), 64'd0);
    tick();
    chk("c1_dec_valid", 64'(dec_valid), 64'd0);
    chk("c1_req_valid", 64'(imem_req_valid), 64'd1);
    chk("c1_req_addr", imem_req_addr, 64'h4);
    tick();
    chk("c2_dec_valid", 64'(dec_valid), 64'd1);
    chk("c2_dec_pc", dec_pc, 64'h0);
    chk("c2_dec_instr", {32'h0, dec_instr}, 64'hD2800020);
    chk("c2_no_credit", 64'(imem_req_valid), 64'd0);
    repeat (6) tick();

    // Decode stall: buffer fills to DEPTH, nothing lost.
    dec_ready = 1'b0;
    repeat (10) tick();
    chk("stall_inflight", 64'(n_reqs - n_pops), 64'd2);
    chk("stall_mem_idle", 64'(mq.size()), 64'd0);
    chk("stall_dec_valid", 64'(dec_valid), 64'd1);
    chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
    chk("stall_head_pc", dec_pc, exp_pc);
    dec_ready = 1'b1;
    repeat (8) tick();

    // Memory back-pressure: address held, PC advances only on handshake.
    imem_req_ready = 1'b0;
    repeat (4) tick();
    saved = n_reqs;
    for (int i = 0; i < 3; i++) begin
      chk("hold_req_valid", 64'(imem_req_valid), 64'd1);
      chk("hold_req_addr", imem_req_addr, exp_req);
      tick();
    end
    chk("hold_no_advance", 64'(n_reqs), 64'(saved));
    imem_req_ready = 1'b1;
    tick();
    chk("hold_release", 64'(n_reqs), 64'(saved + 1));

    // Redirect with two responses outstanding.
    mem_en = 1'b0;
    repeat (4) tick();
    chk("redir_two_outstanding", 64'(mq.size()), 64'd2);
    chk("redir_buf_empty", 64'(dec_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    #1;
    chk("redir_no_req", 64'(imem_req_valid), 64'd0);
    tick();
    chk("redir_tgt_valid", 64'(imem_req_valid), 64'd1);
    chk("redir_tgt_addr", imem_req_addr, 64'h100);
    chk("redir_dec_low", 64'(dec_valid), 64'd0);
    mem_en = 1'b1;
    wait_dec("redir_first_pc", 64'h100);
    repeat (3) tick();

    // Redirect coincident with a pop and a live response.
    k = 0;
    while (!(dec_valid && imem_rsp_valid) && k < 20) begin
      tick();
      k++;
    end
    chk("coinc_found", 64'(dec_valid && imem_rsp_valid), 64'd1);
    saved          = n_pops;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    tick();
    chk("coinc_popped_once", 64'(n_pops), 64'(saved + 1));
    chk("coinc_tgt_valid", 64'(imem_req_valid), 64'd1);
    chk("coinc_tgt_addr", imem_req_addr, 64'h200);
    chk("coinc_dec_low", 64'(dec_valid), 64'd0);
    wait_dec("coinc_first_pc", 64'h200);
    repeat (3) tick();

    // Misaligned redirect target.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h102;
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    chk("align_fault", 64'(fetch_fault), 64'd1);
    saved = n_reqs;
    for (int i = 0; i < 4; i++) begin
      chk("align_halted", 64'(imem_req_valid), 64'd0);
      tick();
    end
    chk("align_no_reqs", 64'(n_reqs), 64'(saved));
    chk("align_fault_sticky", 64'(fetch_fault), 64'd1);
`else
    chk("align_no_fault", 64'(fetch_fault), 64'd0);
    chk("align_req_valid", 64'(imem_req_valid), 64'd1);
    chk("align_req_addr", imem_req_addr, 64'h100);
    wait_dec("align_first_pc", 64'h100);
`endif

    // Asynchronous reset mid-operation.
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("mid_rst_req_addr", imem_req_addr, 64'h0);
    chk("mid_rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("mid_rst_dec_pc", dec_pc, 64'h0);
    chk("mid_rst_fault", 64'(fetch_fault), 64'd0);
    mq.delete();
    mem_en         = 1'b0;
    imem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
